vga_capture: RTL and testbench



---
 rtl/vga_capture.sv | 186 ++++++++++++++++++
 tb/tb_vga_capture.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// VGA frame-capture receiver: recovers line/frame position from the sync edges and
// writes an H_ACT x V_ACT window of every frame into a 32-bit frame buffer.
module vga_capture #(
    parameter int          H_TOTAL   = 800,
    parameter int          V_TOTAL   = 525,
    parameter int          H_START   = 144,
    parameter int          H_ACT     = 320,
    parameter int          V_START   = 35,
    parameter int          V_ACT     = 240,
    parameter logic [17:0] ADDR_BASE = 18'd0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic [7:0]  i_r,
    input  logic [7:0]  i_g,
    input  logic [7:0]  i_b,
    output logic        o_we,
    output logic [17:0] o_addr,
    output logic [31:0] o_wd,
    output logic        o_frame_done,
    output logic        o_locked,
    output logic        o_err
);

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_LO      = 11'(H_START);
    localparam logic [10:0] H_HI      = 11'(H_START + H_ACT);
    localparam logic [9:0]  V_LO      = 10'(V_START);
    localparam logic [9:0]  V_HI      = 10'(V_START + V_ACT);
    localparam logic [17:0] LAST_ADDR = 18'(ADDR_BASE + 18'(H_ACT * V_ACT) - 18'd1);

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t      state_r;
    logic        hs1_r;
    logic        vs1_r;
    logic        hs2_r;
    logic        vs2_r;
    logic [23:0] rgb1_r;
    logic [10:0] h_cnt_r;
    logic [9:0]  v_cnt_r;
    logic [17:0] addr_r;

    logic        hs_fall_s;
    logic        vs_fall_s;
    logic [10:0] h_next_s;
    logic [9:0]  v_next_s;
    logic        in_win_s;
    logic        line_err_s;
    logic        frame_err_s;
    logic        wr_s;

    // Edge detection and position of the pixel currently held in stage 1.
    // h_cnt_r/v_cnt_r trail stage 1 by one cycle, so h_cnt_r at an hs edge is the
    // position of the last pixel of the previous line.
    always_comb begin
        hs_fall_s = ~hs1_r & hs2_r;
        vs_fall_s = ~vs1_r & vs2_r;

        if (hs_fall_s) begin
            h_next_s = 11'd0;
        end else if (h_cnt_r == 11'h7FF) begin
            h_next_s = h_cnt_r;
        end else begin
            h_next_s = h_cnt_r + 11'd1;
        end

        if (vs_fall_s) begin
            v_next_s = 10'd0;
        end else if (hs_fall_s && (v_cnt_r != 10'h3FF)) begin
            v_next_s = v_cnt_r + 10'd1;
        end else begin
            v_next_s = v_cnt_r;
        end

        in_win_s    = (h_next_s >= H_LO) && (h_next_s < H_HI) &&
                      (v_next_s >= V_LO) && (v_next_s < V_HI);
        line_err_s  = hs_fall_s && (h_cnt_r != H_LAST);
        frame_err_s = vs_fall_s && (v_cnt_r != V_LAST);

        if ((state_r == CAPTURE) && in_win_s && !vs_fall_s && !line_err_s) begin
            wr_s = 1'b1;
        end else begin
            wr_s = 1'b0;
        end
    end

    // Input pipeline and line/frame position counters.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            hs1_r   <= 1'b1;
            vs1_r   <= 1'b1;
            hs2_r   <= 1'b1;
            vs2_r   <= 1'b1;
            rgb1_r  <= 24'd0;
            h_cnt_r <= 11'd0;
            v_cnt_r <= 10'd0;
        end else begin
            hs1_r   <= i_hs;
            vs1_r   <= i_vs;
            hs2_r   <= hs1_r;
            vs2_r   <= vs1_r;
            rgb1_r  <= {i_r, i_g, i_b};
            h_cnt_r <= h_next_s;
            v_cnt_r <= v_next_s;
        end
    end

    // Capture FSM, address counter and registered frame-buffer outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_r      <= WAIT_VS;
            addr_r       <= ADDR_BASE;
            o_we         <= 1'b0;
            o_addr       <= ADDR_BASE;
            o_wd         <= 32'd0;
            o_frame_done <= 1'b0;
            o_locked     <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_we         <= 1'b0;
            o_err        <= 1'b0;
            o_frame_done <= o_we && (o_addr == LAST_ADDR);

            if (vs_fall_s) begin
                addr_r <= ADDR_BASE;
            end else if (wr_s) begin
                addr_r <= addr_r + 18'd1;
            end else begin
                addr_r <= addr_r;
            end

            if (wr_s) begin
                o_we   <= 1'b1;
                o_addr <= addr_r;
                o_wd   <= {8'h00, rgb1_r};
            end

            case (state_r)
                WAIT_VS: begin
                    if (vs_fall_s && i_en) begin
                        state_r <= CAPTURE;
                    end else begin
                        state_r <= WAIT_VS;
                    end
                end
                CAPTURE: begin
                    // A vs edge here means the frame ended before the window was filled.
                    if (vs_fall_s || line_err_s) begin
                        o_err    <= 1'b1;
                        o_locked <= 1'b0;
                        state_r  <= WAIT_VS;
                    end else if (wr_s && (addr_r == LAST_ADDR)) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= CAPTURE;
                    end
                end
                DONE: begin
                    if (line_err_s || frame_err_s) begin
                        o_err    <= 1'b1;
                        o_locked <= 1'b0;
                        state_r  <= WAIT_VS;
                    end else if (vs_fall_s) begin
                        o_locked <= 1'b1;
                        state_r  <= i_en ? CAPTURE : WAIT_VS;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= WAIT_VS;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture on a reduced 40x30 link with a 16x12 window.
module tb_vga_capture;

    localparam int          HT = 40;
    localparam int          VT = 30;
    localparam int          HS = 8;
    localparam int          HA = 16;
    localparam int          VS = 4;
    localparam int          VA = 12;
    localparam logic [17:0] AB = 18'd100;
    localparam int          NW = HA * VA;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        hs;
    logic        vs;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        o_we;
    logic [17:0] o_addr;
    logic [31:0] o_wd;
    logic        o_frame_done;
    logic        o_locked;
    logic        o_err;

    always #5 clk = ~clk;

    vga_capture #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .H_ACT(HA),
        .V_START(VS), .V_ACT(VA), .ADDR_BASE(AB)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_hs(hs), .i_vs(vs),
        .i_r(r), .i_g(g), .i_b(b),
        .o_we(o_we), .o_addr(o_addr), .o_wd(o_wd),
        .o_frame_done(o_frame_done), .o_locked(o_locked), .o_err(o_err)
    );

    typedef struct {
        int kind;      // 0 nominal, 1 short line at arg, 2 only arg lines, 3 VT+arg lines
        int arg;
        int en0;       // i_en at frame start
        int en_line;   // line at which i_en toggles, -1 for none
        int exp_wr;
        int exp_done;
        int exp_err;
        int exp_lock;  // o_locked seen at line 1 of this frame
    } vec_t;

    vec_t        vecs [15];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          mark_cyc = 0;
    int          first_wr_cyc = -100;
    int          edge_cyc = 0;
    int          err_cyc = -100;
    logic [17:0] exp_addr = AB;
    logic        prev_last = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: outputs are observed 1 ns after the rising edge and scored.
    task automatic tick();
        int          idx;
        logic [31:0] exp_wd;
        @(posedge clk);
        #1;
        cyc++;
        if (o_we === 1'b1) begin
            idx    = int'(exp_addr - AB);
            exp_wd = {8'h00, 8'(idx / HA), 8'(idx % HA), 8'hA5};
            check("wr_addr", 64'(o_addr), 64'(exp_addr));
            check("wr_data", 64'(o_wd), 64'(exp_wd));
            if (exp_addr == AB) first_wr_cyc = cyc;
            exp_addr = exp_addr + 18'd1;
            wr_cnt++;
        end
        if (o_frame_done === 1'b1) begin
            done_cnt++;
            check("done_after_last_we", 64'(prev_last), 64'd1);
        end
        prev_last = (o_we === 1'b1) && (o_addr == AB + 18'(NW) - 18'd1);
        if (o_err === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if ((o_frame_done === 1'b1) || (o_err === 1'b1) || !rst) exp_addr = AB;
    endtask

    task automatic drive_frame(input int kind, input int arg, input int en0, input int en_line,
                               input int rst_line, output int lock_l1);
        int nlines;
        int len;
        int err_line;
        int wr_snap;
        nlines   = (kind == 2) ? arg : ((kind == 3) ? VT + arg : VT);
        err_line = (kind == 1) ? arg + 1 : 0;
        wr_snap  = 0;
        lock_l1  = 0;
        en       = en0[0];
        for (int line = 0; line < nlines; line++) begin
            len = (kind == 1 && line == arg) ? HT - 1 : HT;
            if (line == en_line) en = ~en0[0];
            for (int col = 0; col < len; col++) begin
                hs  = (col < 4) ? 1'b0 : 1'b1;
                vs  = (line < 2) ? 1'b0 : 1'b1;
                r   = 8'(line - VS);
                g   = 8'(col - HS);
                b   = 8'hA5;
                rst = !(line == rst_line && col >= 12 && col < 15);
                if (line == VS && col == HS) mark_cyc = cyc;
                if (line == err_line && col == 0) edge_cyc = cyc;
                tick();
                if (line == 1 && col == 0) lock_l1 = int'(o_locked);
                if (line == rst_line && col == 12) begin
                    check("rst_we", 64'(o_we), 64'd0);
                    check("rst_addr", 64'(o_addr), 64'(AB));
                    check("rst_wd", 64'(o_wd), 64'd0);
                    check("rst_locked", 64'(o_locked), 64'd0);
                    wr_snap = wr_cnt;
                end
            end
        end
        if (rst_line >= 0) check("no_wr_after_rst", 64'(wr_cnt - wr_snap), 64'd0);
    endtask

    initial begin
        int wr0;
        int dn0;
        int er0;
        int lk;

        vecs[0]  = '{0, 0,  1, -1, NW, 1, 0, 0};
        vecs[1]  = '{0, 0,  1, -1, NW, 1, 0, 1};
        vecs[2]  = '{1, 8,  1, -1, 80, 0, 1, 1};
        vecs[3]  = '{0, 0,  1, -1, NW, 1, 0, 0};
        vecs[4]  = '{0, 0,  1,  9, NW, 1, 0, 1};
        vecs[5]  = '{0, 0,  0, -1, 0,  0, 0, 1};
        vecs[6]  = '{0, 0,  0,  3, 0,  0, 0, 1};
        vecs[7]  = '{0, 0,  1, -1, NW, 1, 0, 1};
        vecs[8]  = '{2, 10, 1, -1, 96, 0, 0, 1};
        vecs[9]  = '{0, 0,  1, -1, 0,  0, 1, 0};
        vecs[10] = '{0, 0,  1, -1, NW, 1, 0, 0};
        vecs[11] = '{0, 0,  1, -1, NW, 1, 0, 1};
        vecs[12] = '{3, 1,  1, -1, NW, 1, 0, 1};
        vecs[13] = '{0, 0,  1, -1, 0,  0, 1, 0};
        vecs[14] = '{0, 0,  1, -1, NW, 1, 0, 0};

        rst = 1'b0;
        en  = 1'b1;
        hs  = 1'b1;
        vs  = 1'b1;
        r   = 8'd0;
        g   = 8'd0;
        b   = 8'd0;
        repeat (3) tick();
        check("reset_we", 64'(o_we), 64'd0);
        check("reset_addr", 64'(o_addr), 64'(AB));
        check("reset_wd", 64'(o_wd), 64'd0);
        check("reset_done", 64'(o_frame_done), 64'd0);
        check("reset_err", 64'(o_err), 64'd0);
        check("reset_locked", 64'(o_locked), 64'd0);
        rst = 1'b1;
        repeat (2) tick();
        check("idle_no_write", 64'(wr_cnt), 64'd0);

        for (int i = 0; i < 15; i++) begin
            wr0 = wr_cnt;
            dn0 = done_cnt;
            er0 = err_cnt;
            drive_frame(vecs[i].kind, vecs[i].arg, vecs[i].en0, vecs[i].en_line, -1, lk);
            check($sformatf("row%0d_writes", i), 64'(wr_cnt - wr0), 64'(vecs[i].exp_wr));
            check($sformatf("row%0d_done", i), 64'(done_cnt - dn0), 64'(vecs[i].exp_done));
            check($sformatf("row%0d_err", i), 64'(err_cnt - er0), 64'(vecs[i].exp_err));
            check($sformatf("row%0d_locked", i), 64'(lk), 64'(vecs[i].exp_lock));
            if (vecs[i].exp_wr > 0)
                check($sformatf("row%0d_latency", i), 64'(first_wr_cyc - mark_cyc), 64'd2);
            if (vecs[i].exp_err > 0)
                check($sformatf("row%0d_err_latency", i), 64'(err_cyc - edge_cyc), 64'd2);
        end

        // Reset asserted for 3 cycles at line 10 of a locked capture frame.
        drive_frame(0, 0, 1, -1, 10, lk);
        check("rstframe_locked_before", 64'(lk), 64'd1);
        wr0 = wr_cnt;
        dn0 = done_cnt;
        drive_frame(0, 0, 1, -1, -1, lk);
        check("after_rst_writes", 64'(wr_cnt - wr0), 64'(NW));
        check("after_rst_done", 64'(done_cnt - dn0), 64'd1);
        check("after_rst_locked", 64'(lk), 64'd0);
        check("after_rst_latency", 64'(first_wr_cyc - mark_cyc), 64'd2);
        wr0 = wr_cnt;
        drive_frame(0, 0, 1, -1, -1, lk);
        check("relock_writes", 64'(wr_cnt - wr0), 64'(NW));
        check("relock_locked", 64'(lk), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
